// File: rtl/cluster_overflow_ctrl.sv
// Cluster count overflow supervisor: threshold compare, stretched flag,
// event counting and per-window peak/average occupancy.
module cluster_overflow_ctrl #(
  parameter int CNT_WIDTH   = 11,
  parameter int WINDOW_LOG2 = 10,
  parameter int EVT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [CNT_WIDTH-1:0] thresh_i,
  input  logic [7:0]           hold_i,
  input  logic [CNT_WIDTH-1:0] cnt_i,
  output logic                 overflow_o,
  output logic [1:0]           state_o,
  output logic [EVT_WIDTH-1:0] evt_cnt_o,
  output logic [CNT_WIDTH-1:0] peak_o,
  output logic [CNT_WIDTH-1:0] avg_o,
  output logic                 window_done_o
);

  localparam int AW = CNT_WIDTH + WINDOW_LOG2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    OVERFLOW = 2'd2,
    HOLDOFF  = 2'd3
  } state_t;

  state_t                 state;
  logic [7:0]             hold_cnt;
  logic                   over;
  logic                   evt_inc;
  logic                   run;
  logic                   win_last;
  logic [AW-1:0]          acc;
  logic [AW-1:0]          sum;
  logic [CNT_WIDTH-1:0]   run_peak;
  logic [CNT_WIDTH-1:0]   peak_nxt;
  logic [WINDOW_LOG2-1:0] win_cnt;

  assign over     = cnt_i > thresh_i;
  assign evt_inc  = enable_i && (state == ARMED) && over;
  assign run      = enable_i && (state != IDLE);
  assign win_last = &win_cnt;
  assign sum      = acc + AW'(cnt_i);
  assign peak_nxt = (cnt_i > run_peak) ? cnt_i : run_peak;
  assign state_o  = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      overflow_o <= 1'b0;
      hold_cnt   <= '0;
    end else if (!enable_i) begin
      state      <= IDLE;
      overflow_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state      <= ARMED;
          overflow_o <= 1'b0;
        end
        ARMED: begin
          if (over) begin
            state      <= OVERFLOW;
            overflow_o <= 1'b1;
          end
        end
        OVERFLOW: begin
          if (!over) begin
            if (hold_i == 8'd0) begin
              state      <= ARMED;
              overflow_o <= 1'b0;
            end else begin
              state    <= HOLDOFF;
              hold_cnt <= hold_i;
            end
          end
        end
        HOLDOFF: begin
          if (over) begin
            state <= OVERFLOW;
          end else if (hold_cnt == 8'd1) begin
            state      <= ARMED;
            overflow_o <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      evt_cnt_o <= '0;
    end else if (clear_i) begin
      evt_cnt_o <= '0;
    end else if (evt_inc && !(&evt_cnt_o)) begin
      evt_cnt_o <= evt_cnt_o + EVT_WIDTH'(1);
    end
  end

  // Leaving the supervised states drops the partial window silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc           <= '0;
      run_peak      <= '0;
      win_cnt       <= '0;
      peak_o        <= '0;
      avg_o         <= '0;
      window_done_o <= 1'b0;
    end else begin
      window_done_o <= 1'b0;
      if (clear_i) begin
        acc      <= '0;
        run_peak <= '0;
        win_cnt  <= '0;
        peak_o   <= '0;
        avg_o    <= '0;
      end else if (!run) begin
        acc      <= '0;
        run_peak <= '0;
        win_cnt  <= '0;
      end else if (win_last) begin
        peak_o        <= peak_nxt;
        avg_o         <= sum[AW-1:WINDOW_LOG2];
        window_done_o <= 1'b1;
        acc           <= '0;
        run_peak      <= '0;
        win_cnt       <= '0;
      end else begin
        acc      <= sum;
        run_peak <= peak_nxt;
        win_cnt  <= win_cnt + WINDOW_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_cluster_overflow_ctrl.sv
// Directed bench for cluster_overflow_ctrl with a 16-clock window
// and a 4-bit event counter so saturation is reachable.
module tb_cluster_overflow_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable_i;
  logic        clear_i;
  logic [10:0] thresh_i;
  logic [7:0]  hold_i;
  logic [10:0] cnt_i;
  logic        overflow_o;
  logic [1:0]  state_o;
  logic [3:0]  evt_cnt_o;
  logic [10:0] peak_o;
  logic [10:0] avg_o;
  logic        window_done_o;

  int n_tests = 0;
  int n_fail  = 0;
  int highs;
  int st2[10] = '{2, 2, 2, 3, 3, 3, 3, 3, 1, 1};
  int st3[6]  = '{3, 3, 3, 3, 3, 1};

  cluster_overflow_ctrl #(
    .CNT_WIDTH  (11),
    .WINDOW_LOG2(4),
    .EVT_WIDTH  (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .thresh_i     (thresh_i),
    .hold_i       (hold_i),
    .cnt_i        (cnt_i),
    .overflow_o   (overflow_o),
    .state_o      (state_o),
    .evt_cnt_o    (evt_cnt_o),
    .peak_o       (peak_o),
    .avg_o        (avg_o),
    .window_done_o(window_done_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input int v);
    cnt_i = 11'(v);
    tick();
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_ovf"},  32'(overflow_o),    0);
    check({tag, "_st"},   32'(state_o),       0);
    check({tag, "_evt"},  32'(evt_cnt_o),     0);
    check({tag, "_peak"}, 32'(peak_o),        0);
    check({tag, "_avg"},  32'(avg_o),         0);
    check({tag, "_done"}, 32'(window_done_o), 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    enable_i = 1'b0;
    clear_i  = 1'b0;
    thresh_i = 11'd100;
    hold_i   = 8'd0;
    cnt_i    = 11'd0;
    #12;
    all_zero("rst");
    reset_n = 1'b1;

    // single-clock overflow with no hold-off
    enable_i = 1'b1;
    step(50);
    check("t1_armed", 32'(state_o), 1);
    step(50);
    check("t1_quiet", 32'(overflow_o), 0);
    step(101);
    check("t1_ovf_hi", 32'(overflow_o), 1);
    check("t1_st_ovf", 32'(state_o), 2);
    check("t1_evt", 32'(evt_cnt_o), 1);
    step(50);
    check("t1_ovf_lo", 32'(overflow_o), 0);
    check("t1_st_arm", 32'(state_o), 1);

    // three over samples then a 5-clock hold-off
    hold_i = 8'd5;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      step(i < 3 ? 200 : 0);
      check($sformatf("t2_st%0d", i), 32'(state_o), 32'(st2[i]));
      check($sformatf("t2_ovf%0d", i), 32'(overflow_o),
            32'(st2[i] >= 2));
      if (overflow_o) highs++;
    end
    check("t2_highs", 32'(highs), 8);
    check("t2_evt", 32'(evt_cnt_o), 2);

    // retrigger during hold-off; hold_i changes mid hold-off are ignored
    step(200);
    check("t3_evt_a", 32'(evt_cnt_o), 3);
    step(0);
    check("t3_hold", 32'(state_o), 3);
    hold_i = 8'd1;
    step(0);
    step(0);
    check("t3_still_hold", 32'(state_o), 3);
    hold_i = 8'd5;
    step(200);
    check("t3_retrig", 32'(state_o), 2);
    check("t3_evt_b", 32'(evt_cnt_o), 3);
    for (int i = 0; i < 6; i++) begin
      step(0);
      check($sformatf("t3_st%0d", i), 32'(state_o), 32'(st3[i]));
    end

    // windows with thresh all-ones: never over
    thresh_i = 11'd2047;
    clear_i = 1'b1;
    step(0);
    clear_i = 1'b0;
    check("t4_clr_evt", 32'(evt_cnt_o), 0);
    for (int i = 0; i < 16; i++) begin
      step(i);
      check($sformatf("t4_done%0d", i), 32'(window_done_o),
            32'(i == 15));
    end
    check("t4_peak", 32'(peak_o), 15);
    check("t4_avg", 32'(avg_o), 7);
    for (int i = 0; i < 16; i++) begin
      step(2047);
      check($sformatf("t4_noovf%0d", i), 32'(overflow_o), 0);
    end
    check("t4_done_max", 32'(window_done_o), 1);
    check("t4_peak_max", 32'(peak_o), 2047);
    check("t4_avg_max", 32'(avg_o), 2047);
    step(0);
    check("t4_done_pulse", 32'(window_done_o), 0);

    // event counter saturation and clear priority
    thresh_i = 11'd100;
    hold_i = 8'd0;
    clear_i = 1'b1;
    step(0);
    clear_i = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(200);
      step(0);
    end
    check("t5_full", 32'(evt_cnt_o), 15);
    step(200);
    step(0);
    check("t5_sat", 32'(evt_cnt_o), 15);
    clear_i = 1'b1;
    step(200);
    clear_i = 1'b0;
    check("t5_clr_evt", 32'(evt_cnt_o), 0);
    check("t5_clr_st", 32'(state_o), 2);
    check("t5_clr_ovf", 32'(overflow_o), 1);
    step(0);

    // enable drop mid-overflow one sample before window end
    clear_i = 1'b1;
    step(0);
    clear_i = 1'b0;
    for (int i = 0; i < 16; i++) step(30);
    check("t6_done", 32'(window_done_o), 1);
    check("t6_peak", 32'(peak_o), 30);
    check("t6_avg", 32'(avg_o), 30);
    for (int i = 0; i < 14; i++) step(10);
    step(200);
    check("t6_in_ovf", 32'(state_o), 2);
    enable_i = 1'b0;
    step(10);
    check("t6_idle", 32'(state_o), 0);
    check("t6_ovf_lo", 32'(overflow_o), 0);
    check("t6_nodone", 32'(window_done_o), 0);
    check("t6_peak_kept", 32'(peak_o), 30);
    check("t6_avg_kept", 32'(avg_o), 30);

    // clear beats a same-cycle window completion
    enable_i = 1'b1;
    step(20);
    for (int i = 0; i < 15; i++) step(20);
    clear_i = 1'b1;
    step(20);
    clear_i = 1'b0;
    check("t6_clr_done", 32'(window_done_o), 0);
    check("t6_clr_peak", 32'(peak_o), 0);
    check("t6_clr_avg", 32'(avg_o), 0);

    // asynchronous reset mid-window while overflowing
    for (int i = 0; i < 5; i++) step(5);
    step(200);
    check("t7_pre_ovf", 32'(overflow_o), 1);
    #2 reset_n = 1'b0;
    #1;
    all_zero("t7_rst");
    enable_i = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("t7_post_st", 32'(state_o), 0);
    check("t7_post_evt", 32'(evt_cnt_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
